memory_access_stage: RTL

//  MEM stage of the pipeline, directly downstream of the EX/MEM register.

---
 rtl/memory_access_stage_pkg.sv | 29 ++
 rtl/memory_access_stage_if.sv | 22 ++
 rtl/memory_access_stage_wb_reg.sv | 29 ++
 rtl/memory_access_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared types for the MEM stage: word/register widths, writeback source,
// memory-access FSM states and the MEM/WB payload.
package memory_access_stage_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } reg_file_data_source_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } mem_fsm_state_t;

  typedef struct packed {
    logic      valid;
    logic      reg_file_write_en;
    reg_addr_t reg_dest_addr;
    word_t     reg_data;
  } wb_payload_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface memory_access_stage_if;
  import memory_access_stage_pkg::*;

  logic  dmem_req;
  logic  dmem_we;
  word_t dmem_addr;
  word_t dmem_wdata;
  logic  dmem_ack;
  word_t dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/memory_access_stage_wb_reg.sv
// MEM/WB pipeline register; a bubble clears valid and write-enable while the
// rest of the payload is don't-care.
module memory_writeback_register
  import memory_access_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        bubble_i,
  input  wb_payload_t payload_i,
  output wb_payload_t payload_o
);

  wb_payload_t payload_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      payload_q <= '0;
    end else begin
      payload_q <= payload_i;
      if (bubble_i) begin
        payload_q.valid             <= 1'b0;
        payload_q.reg_file_write_en <= 1'b0;
      end
    end
  end

  assign payload_o = payload_q;

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, and registers the writeback result.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  is_valid_i,
  input  logic                  mem_write_en_i,
  input  logic                  reg_file_write_en_i,
  input  reg_file_data_source_t reg_file_data_source_i,
  input  reg_addr_t             reg_dest_addr_i,
  input  word_t                 alu_result_i,
  input  word_t                 reg_2_data_i,
  memory_access_stage_if.master dmem,
  output logic                  mem_stall_o,
  output logic                  mem_fault_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_file_write_en_o,
  output reg_addr_t             wb_reg_dest_addr_o,
  output word_t                 wb_reg_data_o
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  mem_fsm_state_t       state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        access;
  logic        req;
  logic        ack;
  logic        timeout;
  logic        stall;
  wb_payload_t wb_d;
  wb_payload_t wb_q;

  // Request/stall decode and FSM next state; ack only counts against a live request.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    wb_d    = '0;

    access  = is_valid_i & (mem_write_en_i | (reg_file_data_source_i == SRC_MEM));
    req     = access & (state_q != ST_FAULT) & reset_n_i;
    ack     = req & dmem.dmem_ack;
    timeout = req & ~ack & (state_q == ST_WAIT) & (cnt_q >= CNT_LAST);
    stall   = req & ~ack & ~timeout;

    unique case (state_q)
      ST_IDLE:  if (stall) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!req || ack) state_d = ST_IDLE;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    // Counts every cycle the request has been waiting, including the issue cycle.
    if (state_d == ST_WAIT) cnt_d = cnt_q + CNT_WIDTH'(1);

    wb_d.valid             = is_valid_i;
    wb_d.reg_file_write_en = is_valid_i & reg_file_write_en_i &
                             ~(access & ((state_q == ST_FAULT) | timeout));
    wb_d.reg_dest_addr     = reg_dest_addr_i;
    wb_d.reg_data          = (reg_file_data_source_i == SRC_MEM) ? dmem.dmem_rdata
                                                                 : alu_result_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  memory_writeback_register u_wb_reg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bubble_i  (stall),
    .payload_i (wb_d),
    .payload_o (wb_q)
  );

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = mem_write_en_i;
  assign dmem.dmem_addr  = alu_result_i;
  assign dmem.dmem_wdata = reg_2_data_i;

  assign mem_stall_o            = stall;
  assign mem_fault_o            = (state_q == ST_FAULT);
  assign wb_valid_o             = wb_q.valid;
  assign wb_reg_file_write_en_o = wb_q.reg_file_write_en;
  assign wb_reg_dest_addr_o     = wb_q.reg_dest_addr;
  assign wb_reg_data_o          = wb_q.reg_data;

endmodule
